line_clear: RTL and testbench

LINE_CLEAR -- requirements
Module: line_clear

---
 rtl/tetris_pkg.sv | 15 +
 rtl/line_clear_score.sv | 22 ++
 rtl/line_clear.sv | 100 ++++++++++
 tb/tb_line_clear.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: shared grid geometry, line-clear FSM states and points table.
// The points table is used by line_clear_score (built only with LINE_CLEAR_SCORE_EN).
package tetris_pkg;
    localparam int GRID_ROWS = 22;
    localparam int GRID_COLS = 10;
    localparam int VIS_ROWS  = 20;

    typedef enum logic [2:0] {IDLE, LOAD, SCAN, SHIFT, DONE} lc_state_t;

    localparam logic [15:0] POINTS [5] = '{16'd0, 16'd40, 16'd100, 16'd300, 16'd1200};

    function automatic logic [15:0] points(input logic [4:0] n);
        return POINTS[(n > 5'd4) ? 3'd4 : n[2:0]];
    endfunction
endpackage

// File: rtl/line_clear_score.sv
// line_clear_score: points lookup and saturating 16-bit score accumulator.
// Instantiated by line_clear only when LINE_CLEAR_SCORE_EN is defined.
module line_clear_score
    import tetris_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        add_i,
    input  logic [4:0]  lines_i,
    output logic [15:0] score_o
);
    logic [15:0] score_q, score_d;
    logic [16:0] sum;

    assign sum     = {1'b0, score_q} + {1'b0, points(lines_i)};
    assign score_d = !add_i ? score_q : sum[16] ? 16'hFFFF : sum[15:0];
    assign score_o = score_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) score_q <= '0;
        else        score_q <= score_d;
endmodule

// File: rtl/line_clear.sv
// line_clear: removes full playfield rows from a locked board, collapsing survivors downward.
// Optional score accumulator enabled by defining LINE_CLEAR_SCORE_EN.
module line_clear
    import tetris_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [GRID_ROWS-1:0][GRID_COLS-1:0]  board_in,
    output logic [GRID_ROWS-1:0][GRID_COLS-1:0]  board_out,
    output logic                                 busy,
    output logic                                 done,
    output logic [4:0]                           lines_cleared
`ifdef LINE_CLEAR_SCORE_EN
    ,
    output logic [15:0]                          score
`endif
);
    lc_state_t                           state_q;
    logic [VIS_ROWS-1:0][GRID_COLS-1:0]  work_q, shift_d, board_q;
    logic [4:0]                          ptr_q, cnt_q, lines_q;
    logic                                busy_q, done_q, row_full, next_full;

    assign board_out     = {{(GRID_ROWS-VIS_ROWS)*GRID_COLS{1'b0}}, board_q};
    assign busy          = busy_q;
    assign done          = done_q;
    assign lines_cleared = lines_q;
    assign row_full      = &work_q[ptr_q];
    // SHIFT also judges the row it pulls into ptr, so a run of full rows costs one cycle per row
    assign next_full     = &shift_d[ptr_q];

    always_comb begin
        shift_d    = work_q;
        shift_d[0] = '0;
        for (int k = 1; k < VIS_ROWS; k++)
            if (5'(k) <= ptr_q) shift_d[k] = work_q[k-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            board_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            lines_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    state_q <= LOAD;
                    busy_q  <= 1'b1;
                end
                LOAD: begin
                    work_q  <= board_in[VIS_ROWS-1:0];
                    ptr_q   <= 5'(VIS_ROWS-1);
                    cnt_q   <= '0;
                    state_q <= SCAN;
                end
                SCAN: if (row_full) state_q <= SHIFT;
                      else if (ptr_q == '0) begin
                          state_q <= DONE;
                          busy_q  <= 1'b0;
                      end else ptr_q <= ptr_q - 5'd1;
                SHIFT: begin
                    work_q <= shift_d;
                    cnt_q  <= cnt_q + 5'd1;
                    if (!next_full) begin
                        if (ptr_q == '0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                        end else begin
                            ptr_q   <= ptr_q - 5'd1;
                            state_q <= SCAN;
                        end
                    end
                end
                DONE: begin
                    board_q <= work_q;
                    lines_q <= cnt_q;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef LINE_CLEAR_SCORE_EN
    line_clear_score u_score (
        .clk     (clk),
        .rst_n   (rst_n),
        .add_i   (state_q == DONE),
        .lines_i (cnt_q),
        .score_o (score)
    );
`endif
endmodule

// File: tb/tb_line_clear.sv
// tb_line_clear: scoreboard bench for line_clear; score checks active with LINE_CLEAR_SCORE_EN.
module tb_line_clear;
    typedef logic [21:0][9:0] board_t;
    typedef struct {
        board_t      board;
        logic [4:0]  lines;
        int          lat;
        logic [15:0] score;
    } exp_t;

    logic        clk, rst_n, start, busy, done;
    board_t      board_in, board_out;
    logic [4:0]  lines_cleared;
    logic [15:0] score;
    int          total = 0, bad = 0, cyc = 0;
    logic [15:0] sc_model = '0;
    exp_t        sbq[$];

    line_clear dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .board_in      (board_in),
        .board_out     (board_out),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared)
`ifdef LINE_CLEAR_SCORE_EN
        ,
        .score         (score)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pts(input int n);
        case (n)
            0: return 16'd0;
            1: return 16'd40;
            2: return 16'd100;
            3: return 16'd300;
            default: return 16'd1200;
        endcase
    endfunction

    // Survivors are gathered bottom-up and repacked against the floor
    function automatic void model(input board_t b, output board_t o, output int n);
        int w = 19;
        o = '0;
        n = 0;
        for (int r = 19; r >= 0; r--)
            if (b[r] == 10'h3FF) n++;
            else begin
                o[w] = b[r];
                w--;
            end
    endfunction

    task automatic op(input board_t b, input int hold);
        exp_t   e;
        board_t eb;
        int     n, s, extra;
        int unsigned sum;
        model(b, eb, n);
        sum      = int'(sc_model) + int'(pts(n));
        sc_model = (sum > 32'hFFFF) ? 16'hFFFF : 16'(sum);
        e.board  = eb;
        e.lines  = 5'(n);
        e.lat    = 22 + n;
        e.score  = sc_model;
        sbq.push_back(e);
        @(negedge clk);
        board_in = b;
        start    = 1'b1;
        s        = cyc;
        repeat (hold) @(negedge clk);
        start = 1'b0;
        chk("busy_run", busy, 1);
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);
        e = sbq.pop_front();
        chk("done_seen", done, 1);
        if (done) begin
            chk("latency", cyc - s - 1, e.lat);
            chk("board_out", board_out, e.board);
            chk("lines", lines_cleared, e.lines);
            chk("busy_done", busy, 0);
`ifdef LINE_CLEAR_SCORE_EN
            chk("score", score, e.score);
`endif
            extra = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                extra += int'(done);
            end
            chk("extra_done", extra, 0);
        end
    endtask

    initial begin
        board_t b;
        rst_n    = 1'b0;
        start    = 1'b0;
        board_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_board", board_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_lines", lines_cleared, 0);
`ifdef LINE_CLEAR_SCORE_EN
        chk("rst_score", score, 0);
`endif
        rst_n = 1'b1;

        op('0, 1);

        b = '0;
        b[19] = 10'h3FF; b[18] = 10'h001; b[20] = 10'h3FF; b[21] = 10'h3FF;
        op(b, 1);

        b = '0;
        b[19] = 10'h3FF; b[17] = 10'h3FF; b[15] = 10'h3FF;
        b[16] = 10'h2AA; b[18] = 10'h155; b[3] = 10'h0F0;
        op(b, 1);

        b = '1;
        op(b, 1);

        for (int t = 0; t < 4; t++) begin
            for (int r = 0; r < 22; r++)
                b[r] = ($urandom % 3 == 0) ? 10'h3FF : 10'($urandom);
            op(b, 1);
        end

        b = '1;
        @(negedge clk);
        board_in = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_board", board_out, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_lines", lines_cleared, 0);
`ifdef LINE_CLEAR_SCORE_EN
        chk("mid_rst_score", score, 0);
`endif
        sc_model = '0;
        @(negedge clk);
        rst_n = 1'b1;
        b = '0;
        b[19] = 10'h3FF; b[18] = 10'h001;
        op(b, 1);

        b = '0;
        b[19] = 10'h3FF; b[18] = 10'h3FF; b[17] = 10'h3FF; b[16] = 10'h3FF; b[15] = 10'h001;
        op(b, 10);

`ifdef LINE_CLEAR_SCORE_EN
        b = '1;
        for (int i = 0; i < 55; i++) op(b, 1);
        chk("score_sat", score, 16'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
